// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter that shares one combinational barrel
// shifter between the execute stage (port 0) and the load/store address unit
// (port 1). A single issue register drives the shifter; each port has a
// depth-1 response buffer returned over valid/ready.
`timescale 1ns/1ps

module shift_arbiter #(
    parameter int unsigned n = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_bit25,
    input  logic [11:0]        req0_imm,
    input  logic [n-1:0]       req0_rm,
    input  logic [n-1:0]       req0_rs,
    input  logic               req0_cin,
    input  logic               req0_use_shifter,
    input  logic [n-1:0]       req0_direct,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_bit25,
    input  logic [11:0]        req1_imm,
    input  logic [n-1:0]       req1_rm,
    input  logic [n-1:0]       req1_rs,
    input  logic               req1_cin,
    input  logic               req1_use_shifter,
    input  logic [n-1:0]       req1_direct,

    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [n-1:0]       rsp0_result,
    output logic               rsp0_carry,

    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [n-1:0]       rsp1_result,
    output logic               rsp1_carry,

    output logic               sh_bit25,
    output logic [11:0]        sh_imm,
    output logic [n-1:0]       sh_rm,
    output logic [n-1:0]       sh_rs,
    output logic               sh_cin,
    output logic               sh_use_shifter,
    output logic [n-1:0]       sh_direct,
    input  logic [n-1:0]       sh_operand2,
    input  logic               sh_carry
);

    localparam int unsigned IMM_W = 12;

    // Shifter request payload as held in the issue register.
    typedef struct packed {
        logic             bit25;
        logic [IMM_W-1:0] imm;
        logic [n-1:0]     rm;
        logic [n-1:0]     rs;
        logic             cin;
        logic             use_shifter;
        logic [n-1:0]     direct;
    } payload_t;

    // IDLE: issue empty. BUSY: issue full, owner buffer empty.
    // STALL: issue full, owner buffer full (advances only when drained).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t   state;
    state_t   state_nxt;

    payload_t issue_q;
    logic     issue_owner;
    logic     ptr;

    payload_t req0_pl;
    payload_t req1_pl;

    logic     issue_valid;
    logic     own_rsp_ready;
    logic     drop;
    logic     advance;
    logic     can_accept;
    logic     v0;
    logic     v1;
    logic     grant0;
    logic     grant1;
    logic     accept;
    logic     cap0;
    logic     cap1;
    logic     rsp0_valid_nxt;
    logic     rsp1_valid_nxt;

    assign req0_pl = {req0_bit25, req0_imm, req0_rm, req0_rs,
                      req0_cin, req0_use_shifter, req0_direct};
    assign req1_pl = {req1_bit25, req1_imm, req1_rm, req1_rs,
                      req1_cin, req1_use_shifter, req1_direct};

    // Shifter inputs come straight from the issue register (zeroed when empty).
    assign sh_bit25       = issue_q.bit25;
    assign sh_imm         = issue_q.imm;
    assign sh_rm          = issue_q.rm;
    assign sh_rs          = issue_q.rs;
    assign sh_cin         = issue_q.cin;
    assign sh_use_shifter = issue_q.use_shifter;
    assign sh_direct      = issue_q.direct;

    // Issue-stage progress, arbitration and response-buffer next-valid terms.
    always_comb begin
        issue_valid    = 1'b0;
        own_rsp_ready  = 1'b0;
        drop           = 1'b0;
        advance        = 1'b0;
        can_accept     = 1'b0;
        v0             = 1'b0;
        v1             = 1'b0;
        grant0         = 1'b0;
        grant1         = 1'b0;
        cap0           = 1'b0;
        cap1           = 1'b0;
        rsp0_valid_nxt = 1'b0;
        rsp1_valid_nxt = 1'b0;

        issue_valid   = (state != ST_IDLE);
        own_rsp_ready = issue_owner ? rsp1_ready : rsp0_ready;
        // A flushed port-0 entry leaves the issue stage without a response.
        drop          = issue_valid & flush & ~issue_owner;
        advance       = ~drop & ((state == ST_BUSY) |
                                 ((state == ST_STALL) & own_rsp_ready));
        can_accept    = ~rst & ((state == ST_IDLE) | advance | drop);

        // Port 0 is masked during flush so port 1 can still win that cycle.
        v0     = req0_valid & ~flush;
        v1     = req1_valid;
        grant0 = v0 & (~v1 | ~ptr);
        grant1 = v1 & ~grant0;

        cap0 = advance & ~issue_owner;
        cap1 = advance & issue_owner;

        rsp0_valid_nxt = flush ? 1'b0 : (cap0 | (rsp0_valid & ~rsp0_ready));
        rsp1_valid_nxt = cap1 | (rsp1_valid & ~rsp1_ready);
    end

    // FSM output decode: request handshakes.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;

        req0_ready = grant0 & can_accept;
        req1_ready = grant1 & can_accept;
        accept     = req0_ready | req1_ready;
    end

    // FSM next state: occupancy and owner-buffer status of the next issue entry.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (req1_ready ? rsp1_valid_nxt : rsp0_valid_nxt) begin
                state_nxt = ST_STALL;
            end else begin
                state_nxt = ST_BUSY;
            end
        end else if (advance | drop) begin
            state_nxt = ST_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue register: load the winner, clear when the entry leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q     <= '0;
            issue_owner <= 1'b0;
        end else if (accept) begin
            issue_q     <= req1_ready ? req1_pl : req0_pl;
            issue_owner <= req1_ready;
        end else if (advance | drop) begin
            issue_q     <= '0;
            issue_owner <= 1'b0;
        end
    end

    // Round-robin pointer flips only when the favoured port is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept && (req1_ready == ptr)) begin
            ptr <= ~ptr;
        end
    end

    // Port-0 response buffer (cleared by flush).
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_carry  <= 1'b0;
        end else begin
            rsp0_valid <= rsp0_valid_nxt;
            if (cap0) begin
                rsp0_result <= sh_operand2;
                rsp0_carry  <= sh_carry;
            end
        end
    end

    // Port-1 response buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_carry  <= 1'b0;
        end else begin
            rsp1_valid <= rsp1_valid_nxt;
            if (cap1) begin
                rsp1_result <= sh_operand2;
                rsp1_carry  <= sh_carry;
            end
        end
    end

    // Structural invariants of the arbiter.
    a_one_ready : assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));
    a_busy_empty : assert property (@(posedge clk) disable iff (rst)
        (state == ST_BUSY) |-> !(issue_owner ? rsp1_valid : rsp0_valid));
    a_stall_full : assert property (@(posedge clk) disable iff (rst)
        (state == ST_STALL) |-> (issue_owner ? rsp1_valid : rsp0_valid));

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus a randomized
// run scored against a queue-based transaction model and an ARM shifter model.
`timescale 1ns/1ps

module tb_shift_arbiter;

    typedef struct packed {
        logic        bit25;
        logic [11:0] imm;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        cin;
        logic        use_sh;
        logic [31:0] direct;
    } txn_t;

    typedef struct packed {
        logic owner;
        txn_t t;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req0_valid, req0_ready, req0_bit25, req0_cin, req0_use_shifter;
    logic [11:0] req0_imm;
    logic [31:0] req0_rm, req0_rs, req0_direct;
    logic        req1_valid, req1_ready, req1_bit25, req1_cin, req1_use_shifter;
    logic [11:0] req1_imm;
    logic [31:0] req1_rm, req1_rs, req1_direct;
    logic        rsp0_valid, rsp0_ready, rsp0_carry;
    logic [31:0] rsp0_result;
    logic        rsp1_valid, rsp1_ready, rsp1_carry;
    logic [31:0] rsp1_result;
    logic        sh_bit25, sh_cin, sh_use_shifter, sh_carry;
    logic [11:0] sh_imm;
    logic [31:0] sh_rm, sh_rs, sh_direct, sh_operand2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.n(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bit25(req0_bit25),
        .req0_imm(req0_imm), .req0_rm(req0_rm), .req0_rs(req0_rs), .req0_cin(req0_cin),
        .req0_use_shifter(req0_use_shifter), .req0_direct(req0_direct),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bit25(req1_bit25),
        .req1_imm(req1_imm), .req1_rm(req1_rm), .req1_rs(req1_rs), .req1_cin(req1_cin),
        .req1_use_shifter(req1_use_shifter), .req1_direct(req1_direct),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_carry(rsp0_carry),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_carry(rsp1_carry),
        .sh_bit25(sh_bit25), .sh_imm(sh_imm), .sh_rm(sh_rm), .sh_rs(sh_rs),
        .sh_cin(sh_cin), .sh_use_shifter(sh_use_shifter), .sh_direct(sh_direct),
        .sh_operand2(sh_operand2), .sh_carry(sh_carry)
    );

    // ARM data-processing operand2 behaviour; returns {carry, result}.
    function automatic logic [32:0] arm_shift(input txn_t t);
        logic [31:0] rm, r, imm8;
        logic        c;
        int          amt;
        logic [1:0]  typ;
        rm = t.rm;
        c  = t.cin;
        r  = rm;
        if (!t.use_sh) return {t.cin, t.direct};
        if (t.bit25) begin
            imm8 = {24'd0, t.imm[7:0]};
            amt  = 2 * int'(t.imm[11:8]);
            if (amt == 0) return {t.cin, imm8};
            r = (imm8 >> amt) | (imm8 << (32 - amt));
            return {r[31], r};
        end
        typ = t.imm[6:5];
        if (!t.imm[4]) begin
            amt = int'(t.imm[11:7]);
            if (amt == 0) begin
                if (typ == 2'd0) return {t.cin, rm};
                if (typ == 2'd3) return {rm[0], t.cin, rm[31:1]};
                amt = 32;
            end
        end else begin
            amt = int'(t.rs[7:0]);
            if (amt == 0) return {t.cin, rm};
        end
        case (typ)
            2'd0: begin
                if (amt < 32) begin r = rm << amt; c = rm[5'(32 - amt)]; end
                else if (amt == 32) begin r = '0; c = rm[0]; end
                else begin r = '0; c = 1'b0; end
            end
            2'd1: begin
                if (amt < 32) begin r = rm >> amt; c = rm[5'(amt - 1)]; end
                else if (amt == 32) begin r = '0; c = rm[31]; end
                else begin r = '0; c = 1'b0; end
            end
            2'd2: begin
                if (amt < 32) begin r = 32'($signed(rm) >>> amt); c = rm[5'(amt - 1)]; end
                else begin r = {32{rm[31]}}; c = rm[31]; end
            end
            default: begin
                amt = amt % 32;
                if (amt == 0) begin r = rm; c = rm[31]; end
                else begin r = (rm >> amt) | (rm << (32 - amt)); c = rm[5'(amt - 1)]; end
            end
        endcase
        return {c, r};
    endfunction

    // Combinational shifter attached to the DUT's shifter port.
    txn_t sh_t;
    always_comb begin
        sh_t = {sh_bit25, sh_imm, sh_rm, sh_rs, sh_cin, sh_use_shifter, sh_direct};
        {sh_carry, sh_operand2} = arm_shift(sh_t);
    end

    function automatic txn_t mk_direct(input logic [31:0] d, input logic c);
        txn_t t;
        t        = '0;
        t.direct = d;
        t.cin    = c;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.bit25  = 1'($urandom_range(1));
        t.imm    = 12'($urandom);
        t.rm     = $urandom;
        t.rs     = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(40));
        t.cin    = 1'($urandom_range(1));
        t.use_sh = ($urandom_range(3) != 0);
        t.direct = $urandom;
        return t;
    endfunction

    task automatic set_req(input int p, input logic v, input txn_t t);
        if (p == 0) begin
            req0_valid = v; req0_bit25 = t.bit25; req0_imm = t.imm; req0_rm = t.rm;
            req0_rs = t.rs; req0_cin = t.cin; req0_use_shifter = t.use_sh; req0_direct = t.direct;
        end else begin
            req1_valid = v; req1_bit25 = t.bit25; req1_imm = t.imm; req1_rm = t.rm;
            req1_rs = t.rs; req1_cin = t.cin; req1_use_shifter = t.use_sh; req1_direct = t.direct;
        end
    endtask

    task automatic clear_inputs();
        flush      = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        txn_t sh_now;
        rst = 1'b1;
        clear_inputs();
        set_req(0, 1'b1, mk_direct(32'h1, 1'b0));
        set_req(1, 1'b1, mk_direct(32'h2, 1'b0));
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        tick();
        sh_now = sh_t;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        checks++; if ({rsp0_carry, rsp0_result, rsp1_carry, rsp1_result} !== 66'd0) begin errors++;
            $display("FAIL reset_rsp_data: got %h %h expected 0", rsp0_result, rsp1_result); end
        checks++; if (sh_now !== txn_t'(0)) begin errors++;
            $display("FAIL reset_sh: got %h expected 0", sh_now); end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lsl_imm();
        txn_t t;
        do_reset();
        t = '0; t.imm = 12'h100; t.rm = 32'h0000_0003; t.use_sh = 1'b1;
        set_req(0, 1'b1, t);
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++;
            $display("FAIL lsl_accept: got %b expected 1", req0_ready); end
        tick();
        set_req(0, 1'b0, '0);
        #1;
        checks++; if (sh_rm !== 32'h3 || sh_imm !== 12'h100 || sh_use_shifter !== 1'b1) begin errors++;
            $display("FAIL lsl_issue: got rm=%h imm=%h use=%b expected 3 100 1", sh_rm, sh_imm, sh_use_shifter); end
        checks++; if (rsp0_valid !== 1'b0) begin errors++;
            $display("FAIL lsl_early_valid: got %b expected 0", rsp0_valid); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h0000_000C || rsp0_carry !== 1'b0) begin errors++;
            $display("FAIL lsl_result: got v=%b %h c=%b expected 1 0000000c 0", rsp0_valid, rsp0_result, rsp0_carry); end
        checks++; if (sh_use_shifter !== 1'b0) begin errors++;
            $display("FAIL lsl_issue_empty: got %b expected 0", sh_use_shifter); end
        rsp0_ready = 1'b1;
        tick();
        checks++; if (rsp0_valid !== 1'b0) begin errors++;
            $display("FAIL lsl_drain: got %b expected 0", rsp0_valid); end
    endtask

    task automatic test_rotate_imm();
        txn_t t;
        do_reset();
        t = '0; t.bit25 = 1'b1; t.imm = 12'h4FF; t.use_sh = 1'b1;
        set_req(1, 1'b1, t);
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++;
            $display("FAIL rot_accept: got %b expected 1", req1_ready); end
        tick();
        set_req(1, 1'b0, '0);
        tick();
        checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hFF00_0000 || rsp1_carry !== 1'b1) begin errors++;
            $display("FAIL rot_result: got v=%b %h c=%b expected 1 ff000000 1", rsp1_valid, rsp1_result, rsp1_carry); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_d;
        int          e;
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            set_req(0, 1'b1, mk_direct(32'hA000_0000 + 32'(k), 1'(k)));
            set_req(1, 1'b1, mk_direct(32'hB000_0000 + 32'(k), 1'(k)));
            #1;
            checks++; if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin errors++;
                $display("FAIL contention_grant k=%0d: got %b%b expected port %0d", k, req0_ready, req1_ready, k % 2); end
            if (k >= 2) begin
                e     = (k - 2) % 2;
                exp_d = ((e == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(k - 2);
                if (e == 0) begin
                    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 ||
                                  rsp0_result !== exp_d || rsp0_carry !== 1'(k - 2)) begin errors++;
                        $display("FAIL contention_rsp k=%0d: got v=%b%b %h expected 10 %h", k, rsp0_valid, rsp1_valid, rsp0_result, exp_d); end
                end else begin
                    checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 ||
                                  rsp1_result !== exp_d || rsp1_carry !== 1'(k - 2)) begin errors++;
                        $display("FAIL contention_rsp k=%0d: got v=%b%b %h expected 01 %h", k, rsp0_valid, rsp1_valid, rsp1_result, exp_d); end
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        txn_t held;
        do_reset();
        set_req(0, 1'b1, mk_direct(32'h1111, 1'b0));
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++;
            $display("FAIL bp_accept_a: got %b expected 1", req0_ready); end
        tick();
        set_req(0, 1'b1, mk_direct(32'h2222, 1'b1));
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++;
            $display("FAIL bp_accept_b: got %b expected 1", req0_ready); end
        tick();
        set_req(0, 1'b1, mk_direct(32'h3333, 1'b0));
        #1;
        held = sh_t;
        checks++; if (req0_ready !== 1'b0 || sh_direct !== 32'h2222) begin errors++;
            $display("FAIL bp_stall: got ready=%b sh=%h expected 0 2222", req0_ready, sh_direct); end
        checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h1111) begin errors++;
            $display("FAIL bp_held_a: got v=%b %h expected 1 1111", rsp0_valid, rsp0_result); end
        tick();
        checks++; if (req0_ready !== 1'b0 || sh_t !== held || rsp0_result !== 32'h1111) begin errors++;
            $display("FAIL bp_stable: got ready=%b sh=%h rsp=%h expected 0 %h 1111", req0_ready, sh_t, rsp0_result, held); end
        set_req(0, 1'b0, '0);
        rsp0_ready = 1'b1;
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h2222 || rsp0_carry !== 1'b1) begin errors++;
            $display("FAIL bp_release_b: got v=%b %h c=%b expected 1 2222 1", rsp0_valid, rsp0_result, rsp0_carry); end
        tick();
        checks++; if (rsp0_valid !== 1'b0) begin errors++;
            $display("FAIL bp_drained: got %b expected 0", rsp0_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        set_req(1, 1'b1, mk_direct(32'h5555, 1'b1));
        tick();
        set_req(1, 1'b0, '0);
        set_req(0, 1'b1, mk_direct(32'h6666, 1'b0));
        tick();
        flush = 1'b1;
        set_req(0, 1'b1, mk_direct(32'h8888, 1'b0));
        set_req(1, 1'b1, mk_direct(32'h7777, 1'b0));
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++;
            $display("FAIL flush_grant: got %b%b expected 01", req0_ready, req1_ready); end
        tick();
        clear_inputs();
        #1;
        checks++; if (rsp0_valid !== 1'b0) begin errors++;
            $display("FAIL flush_rsp0: got %b expected 0", rsp0_valid); end
        checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h5555 || rsp1_carry !== 1'b1) begin errors++;
            $display("FAIL flush_rsp1_intact: got v=%b %h c=%b expected 1 5555 1", rsp1_valid, rsp1_result, rsp1_carry); end
        checks++; if (sh_direct !== 32'h7777) begin errors++;
            $display("FAIL flush_issue: got %h expected 7777", sh_direct); end
        tick();
        rsp1_ready = 1'b1;
        checks++; if (rsp0_valid !== 1'b0) begin errors++;
            $display("FAIL flush_rsp0_late: got %b expected 0", rsp0_valid); end
        tick();
        checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h7777) begin errors++;
            $display("FAIL flush_port1_result: got v=%b %h expected 1 7777", rsp1_valid, rsp1_result); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_req(0, 1'b1, mk_direct(32'hAAAA, 1'b0));
        tick();
        set_req(0, 1'b1, mk_direct(32'hBBBB, 1'b0));
        tick();
        set_req(0, 1'b0, '0);
        #1;
        checks++; if (sh_direct !== 32'hBBBB || rsp0_valid !== 1'b1) begin errors++;
            $display("FAIL rmid_stall_setup: got sh=%h v=%b expected bbbb 1", sh_direct, rsp0_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || req0_ready !== 1'b0 ||
                      req1_ready !== 1'b0 || sh_use_shifter !== 1'b0 || sh_direct !== 32'h0) begin errors++;
            $display("FAIL rmid_cleared: got v=%b%b r=%b%b use=%b sh=%h expected all 0",
                     rsp0_valid, rsp1_valid, req0_ready, req1_ready, sh_use_shifter, sh_direct); end
        set_req(0, 1'b1, mk_direct(32'h1, 1'b0));
        set_req(1, 1'b1, mk_direct(32'h2, 1'b0));
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL rmid_pointer: got %b%b expected 10", req0_ready, req1_ready); end
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        iss_t        iss_q[$];
        logic [32:0] rq0[$];
        logic [32:0] rq1[$];
        logic        m_ptr, own, own_full, own_rdy, m_busy, m_drop, m_adv, m_can;
        logic        g0, g1, e_r0, e_r1;
        logic [32:0] res;
        txn_t        t0, t1, exp_sh;
        do_reset();
        m_ptr = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            t0 = rand_txn();
            t1 = rand_txn();
            rst        = ($urandom_range(199) == 0);
            flush      = ($urandom_range(19) == 0);
            rsp0_ready = ($urandom_range(99) < 65);
            rsp1_ready = ($urandom_range(99) < 65);
            set_req(0, ($urandom_range(99) < 60), t0);
            set_req(1, ($urandom_range(99) < 60), t1);
            #1;
            m_busy   = (iss_q.size() != 0);
            own      = m_busy ? iss_q[0].owner : 1'b0;
            own_full = own ? (rq1.size() != 0) : (rq0.size() != 0);
            own_rdy  = own ? rsp1_ready : rsp0_ready;
            m_drop   = m_busy && flush && !own;
            m_adv    = m_busy && !m_drop && (!own_full || own_rdy);
            m_can    = !rst && (!m_busy || m_adv || m_drop);
            g0       = req0_valid && !flush && (!req1_valid || !m_ptr);
            g1       = req1_valid && !g0;
            e_r0     = g0 && m_can;
            e_r1     = g1 && m_can;
            exp_sh   = m_busy ? iss_q[0].t : '0;
            checks++; if (req0_ready !== e_r0 || req1_ready !== e_r1) begin errors++;
                $display("FAIL rand_ready cyc=%0d: got %b%b expected %b%b", cyc, req0_ready, req1_ready, e_r0, e_r1); end
            checks++; if (rsp0_valid !== (rq0.size() != 0) || rsp1_valid !== (rq1.size() != 0)) begin errors++;
                $display("FAIL rand_rsp_valid cyc=%0d: got %b%b expected %b%b", cyc, rsp0_valid, rsp1_valid,
                         rq0.size() != 0, rq1.size() != 0); end
            if (rq0.size() != 0) begin
                checks++; if ({rsp0_carry, rsp0_result} !== rq0[0]) begin errors++;
                    $display("FAIL rand_rsp0 cyc=%0d: got %h expected %h", cyc, {rsp0_carry, rsp0_result}, rq0[0]); end
            end
            if (rq1.size() != 0) begin
                checks++; if ({rsp1_carry, rsp1_result} !== rq1[0]) begin errors++;
                    $display("FAIL rand_rsp1 cyc=%0d: got %h expected %h", cyc, {rsp1_carry, rsp1_result}, rq1[0]); end
            end
            checks++; if (sh_t !== exp_sh) begin errors++;
                $display("FAIL rand_sh cyc=%0d: got %h expected %h", cyc, sh_t, exp_sh); end
            // Advance the transaction model across the coming edge.
            if (rst) begin
                iss_q.delete(); rq0.delete(); rq1.delete();
                m_ptr = 1'b0;
            end else begin
                res = m_busy ? arm_shift(iss_q[0].t) : 33'd0;
                if (flush) rq0.delete();
                else if (rq0.size() != 0 && rsp0_ready) void'(rq0.pop_front());
                if (rq1.size() != 0 && rsp1_ready) void'(rq1.pop_front());
                if (m_adv && !own) rq0.push_back(res);
                if (m_adv && own)  rq1.push_back(res);
                if (m_adv || m_drop) void'(iss_q.pop_front());
                if (e_r0) iss_q.push_back('{owner: 1'b0, t: t0});
                if (e_r1) iss_q.push_back('{owner: 1'b1, t: t1});
                if ((e_r0 && !m_ptr) || (e_r1 && m_ptr)) m_ptr = !m_ptr;
            end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_lsl_imm();
        test_rotate_imm();
        test_contention();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares the single barrel shifter between two requesters: port 0, the execute stage (operand2 generation), and port 1, the load/store address unit (scaled register offsets).
- Arbitrates round-robin and registers the winning request into an issue stage that drives the shifter.
- Captures the shifter result and carry into a per-requester response buffer, returned via valid/ready.
- Sits between the pipeline front end and the shifter; the shifter stays purely combinational.

Parameters:
n, 32, datapath width (Rm, Rs, direct data, result)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush; discards port-0 work
req0_valid, req1_valid  in  1  request present
req0_ready, req1_ready  out  1  request accepted this cycle when valid&ready
reqN_bit25  in  1  instruction bit 25 (immediate rotate form)
reqN_imm  in  12  instruction bits 11..0
reqN_rm, reqN_rs  in  n  register operands
reqN_cin  in  1  current C flag
reqN_use_shifter  in  1  1 = shifted result, 0 = pass direct data
reqN_direct  in  n  bypass data
rspN_valid  out  1  result available for requester N
rspN_ready  in  1  requester N consumes result
rspN_result  out  n  shifter operand2
rspN_carry  out  1  shifter carry-out
sh_bit25, sh_imm, sh_rm, sh_rs, sh_cin, sh_use_shifter, sh_direct  out  1/12/n/n/1/1/n  drive shifter inputs
sh_operand2  in  n  shifter result
sh_carry  in  1  shifter carry-out

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: issue stage empty, FSM in IDLE, round-robin pointer = port 0. rspN_valid, reqN_ready, rspN_result, rspN_carry and all sh_* outputs are 0.
- Latency: a request accepted at edge t drives sh_* from the issue register during cycle t+1. The result is captured at edge t+1, and rspN_valid is high from cycle t+2.
- Throughput: one request per cycle when responses are drained.
- Issue register fields: payload, owner id (0/1), valid. When empty, all sh_* = 0 (use_shifter = 0).
- FSM states:
  - IDLE: issue stage empty. Goes to BUSY on accept.
  - BUSY: issue full and the owner's response buffer is empty or being drained this cycle. Result moves to the response buffer. Next state is BUSY if a new accept occurs, otherwise IDLE.
  - STALL: issue full and the owner's response buffer is full with rspN_ready = 0. Holds the issue register and sh_* stable. Goes to BUSY when the owner asserts rspN_ready.
- can_accept = issue empty, or issue advancing this edge (IDLE, or BUSY-and-advancing).
- Arbitration: if both ports are valid, the pointer port wins. Pointer flips to the other port after every grant to the pointer port. A single valid port wins regardless of pointer.
- reqN_ready = grant_N & can_accept & !(N==0 & flush). Ready may depend combinationally on valid. At most one ready high per cycle.
- Response buffer per port: depth 1. Holds result/carry stable while rspN_valid & !rspN_ready. Cleared on handshake unless refilled the same edge (back-to-back valid stays high).
- flush:
  - Clears rsp0_valid.
  - Empties the issue stage if its owner is 0.
  - Blocks port-0 accept that cycle.
  - Port-1 issue and response are unaffected, and port 1 may be granted in the flush cycle.
- Simultaneous flush with port-0 response handshake: handshake is ignored, buffer cleared.
- rst mid-operation: all state returns to reset values at the next edge; in-flight work is dropped with no response.

Test Plan:
- LSL by immediate: req0 imm=12'h100, rm=32'h0000_0003, cin=0, use_shifter=1, bit25=0, accepted at cycle 1 -> rsp0_valid at cycle 3, rsp0_result=32'h0000_000C, rsp0_carry=0.
- Rotate immediate: req1 bit25=1, imm=12'h4FF, cin=0 -> rsp1_result=32'hFF00_0000, rsp1_carry=1, two cycles after accept.
- Contention: both ports valid continuously from reset with responses drained -> grants 0,1,0,1..., one accept per cycle, no cycle with both readys high.
- Backpressure: rsp0_ready=0, two port-0 requests issued -> first held in rsp0, second sits in issue (STALL), req0_ready=0, sh_* stable. Raising rsp0_ready releases the second result one cycle later.
- Flush: port-0 request in issue, port-1 response pending, flush=1 for one cycle -> rsp0_valid never rises, rsp1 data intact, port-1 request granted that cycle.
- Reset mid-op: rst during STALL -> next cycle all valids/readys 0, sh_use_shifter=0, pointer=0.
